// File: rtl/btn_hex_pkg.sv
// Shared constants for the button-driven hex entry path.
// Button indices, digit count and debounce counter sizing helpers.
package btn_hex_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_CLR   = 4;
  localparam int NUM_BTN   = 5;

  localparam int NUM_DIGITS = 4;

  // Debounce counter width for the production debounce length.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int DB_CNT_W            = $clog2(DEBOUNCE_CYCLES_DEF);

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Action chosen by the arbiter for the current cycle.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLR,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } act_e;

endpackage

// File: rtl/btn_hex_entry_debounce.sv
// Per-button conditioning: 2-flop synchronizer, debounce counter and
// rising-edge detector. level_o is the accepted (debounced) level,
// press_o a registered one-cycle pulse on each accepted press.
module btn_debounce
  import btn_hex_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= ~stable_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Registered press pulse on the rising edge of the accepted level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/btn_hex_entry.sv
// Button-driven 4-digit hex editor feeding the seven-segment display stage.
// Debounces UP/DOWN/LEFT/RIGHT/CLR, arbitrates one action per cycle
// (CLR > UP > DOWN > LEFT > RIGHT) and holds VALUE/CURSOR/CUR_AN.
// Optional macro BTN_HEX_AUTO_REPEAT_EN adds auto-repeat on UP and DOWN.
module btn_hex_entry
  import btn_hex_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic               CLK_100MHZ,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [15:0]        VALUE,
  output logic [1:0]         CURSOR,
  output logic [3:0]         CUR_AN,
  output logic               CHANGED
);

  logic [NUM_BTN-1:0] level, press;
  logic               up_evt, down_evt;
  act_e               act;

  logic [15:0] value_q, value_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [3:0]  cur_an_q;
  logic        act_q, changed_q;
  logic [3:0]  dig;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (CLK_100MHZ),
      .rst_i   (RST),
      .btn_i   (BTN[i]),
      .level_o (level[i]),
      .press_o (press[i])
    );
  end

`ifdef BTN_HEX_AUTO_REPEAT_EN
  localparam int RW = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [1:0] rpt_pulse;

  // UP (0) and DOWN (1) share button index and repeat slot.
  for (genvar r = 0; r < 2; r++) begin : g_rpt
    logic [RW-1:0] rcnt_q;
    logic          ron_q;

    assign rpt_pulse[r] = ron_q & level[r] & (rcnt_q == '0);

    // Count down from the press to the first repeat, then between repeats.
    always_ff @(posedge CLK_100MHZ or posedge RST) begin
      if (RST) begin
        ron_q  <= 1'b0;
        rcnt_q <= '0;
      end else if (!level[r]) begin
        ron_q  <= 1'b0;
        rcnt_q <= '0;
      end else if (press[r]) begin
        ron_q  <= 1'b1;
        rcnt_q <= RW'(REPEAT_DELAY - 1);
      end else if (rpt_pulse[r]) begin
        rcnt_q <= RW'(REPEAT_PERIOD - 1);
      end else if (ron_q) begin
        rcnt_q <= rcnt_q - RW'(1);
      end
    end
  end

  assign up_evt   = press[BTN_UP]   | rpt_pulse[BTN_UP];
  assign down_evt = press[BTN_DOWN] | rpt_pulse[BTN_DOWN];
`else
  assign up_evt   = press[BTN_UP];
  assign down_evt = press[BTN_DOWN];
`endif

  // Levels are only consumed by the repeat logic; keep lint quiet otherwise.
  logic unused_cfg;
  assign unused_cfg = ^{level, REPEAT_DELAY[0], REPEAT_PERIOD[0]};

  // Fixed-priority arbiter; losing pulses are dropped.
  always_comb begin
    act = ACT_NONE;
    if      (press[BTN_CLR])   act = ACT_CLR;
    else if (up_evt)           act = ACT_UP;
    else if (down_evt)         act = ACT_DOWN;
    else if (press[BTN_LEFT])  act = ACT_LEFT;
    else if (press[BTN_RIGHT]) act = ACT_RIGHT;
  end

  // Next value/cursor for the selected action.
  always_comb begin
    value_d  = value_q;
    cursor_d = cursor_q;
    dig      = value_q[{cursor_q, 2'b00} +: 4];
    case (act)
      ACT_CLR:   value_d = '0;
      ACT_UP:    value_d[{cursor_q, 2'b00} +: 4] = dig + 4'd1;
      ACT_DOWN:  value_d[{cursor_q, 2'b00} +: 4] = dig - 4'd1;
      ACT_LEFT:  cursor_d = cursor_q + 2'd1;
      ACT_RIGHT: cursor_d = cursor_q - 2'd1;
      default:   ;
    endcase
  end

  // Output registers; CHANGED trails the update by one cycle.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      value_q   <= '0;
      cursor_q  <= '0;
      cur_an_q  <= 4'b1110;
      act_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      cursor_q  <= cursor_d;
      cur_an_q  <= ~(4'b0001 << cursor_d);
      act_q     <= (act != ACT_NONE);
      changed_q <= act_q;
    end
  end

  assign VALUE   = value_q;
  assign CURSOR  = cursor_q;
  assign CUR_AN  = cur_an_q;
  assign CHANGED = changed_q;

endmodule
